cdf_write_arbiter: RTL

//   Shares the single pixel/CDF memory write port among NUM_REQ pipeline stages
//   (histogram update, CDF store, equalise write-back, host fill).

---
 rtl/cdf_write_arbiter_if.sv | 32 +++
 rtl/cdf_write_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cdf_write_arbiter_if.sv
// Write-port bundle between the pipeline stages and the shared memory write
// port. The master side is the stage/memory environment and the slave side is
// the arbiter.
interface cdf_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 128
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_stall;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [OWN_W-1:0]          owner;
  logic                      locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data, mem_stall,
    input  req_ready, mem_we, mem_addr, mem_wdata, owner, locked
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data, mem_stall,
    output req_ready, mem_we, mem_addr, mem_wdata, owner, locked
  );
endinterface

// File: rtl/cdf_write_arbiter.sv
// Round-robin arbiter for the single pixel/CDF memory write port. Supports
// locked bursts of up to LOCK_MAX transfers and a registered write stage that
// holds under mem_stall. One write per cycle when the memory is not stalling.
module cdf_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 128,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cdf_write_arbiter_if.slave   wr_if
);
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OWN_W-1:0]   ptr_q, ptr_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               adv;
  logic               found;
  logic [OWN_W-1:0]   winner;
  logic               xfer;
  logic [NUM_REQ-1:0] ready;

  // The output register may take a new write unless it holds one under stall.
  assign adv = !wr_if.mem_stall || !we_q;

  // Pick the candidate: the lock owner in LOCKED, else first valid from ptr.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    if (state_q == ST_LOCKED) begin
      found  = wr_if.req_valid[owner_q];
      winner = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_REQ;
        if (!found && wr_if.req_valid[idx]) begin
          found  = 1'b1;
          winner = OWN_W'(idx);
        end
      end
    end
  end

  // Grant is one-hot on the candidate, suppressed under stall or reset.
  always_comb begin
    xfer  = adv && found && reset_n;
    ready = '0;
    if (xfer) ready[winner] = 1'b1;
  end

  // Next-state logic for the FSM, pointer, burst count and write stage.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (adv) begin
      we_d   = xfer;
      addr_d = '0;
      data_d = '0;
      if (xfer) begin
        addr_d  = wr_if.req_addr[int'(winner)*ADDR_W +: ADDR_W];
        data_d  = wr_if.req_data[int'(winner)*DATA_W +: DATA_W];
        owner_d = winner;
        ptr_d   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
      end
      case (state_q)
        ST_ARB: begin
          if (xfer && wr_if.req_lock[winner] && LOCK_MAX > 1) begin
            state_d = ST_LOCKED;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          if (xfer) begin
            if (!wr_if.req_lock[winner] || cnt_q == CNT_W'(LOCK_MAX - 1)) begin
              state_d = ST_ARB;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (!wr_if.req_lock[owner_q]) begin
            // Owner is neither writing nor asking to keep the port.
            state_d = ST_ARB;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_ARB;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and write-stage registers, all cleared by the async reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      // NOTE: the wide data register is reset too, because idle must present
      // zero data on the memory port, not whatever was last written.
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_if.req_ready = ready;
  assign wr_if.mem_we    = we_q;
  assign wr_if.mem_addr  = addr_q;
  assign wr_if.mem_wdata = data_q;
  assign wr_if.owner     = owner_q;
  assign wr_if.locked    = (state_q == ST_LOCKED);
endmodule
